// File: rtl/dmem_ctrl.sv
// Data memory controller: valid/ready request/response, configurable access
// latency, byte-lane stores and sign/zero-extended loads with fault checking.
module dmem_ctrl #(
  parameter int XLEN       = 32,
  parameter int DMEM_POWER = 18,
  parameter int LATENCY    = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_write,
  input  logic [1:0]      req_size,
  input  logic            req_unsigned,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_err
);

  localparam int NB = XLEN / 8;
  localparam int LB = $clog2(NB);
  localparam int AW = DMEM_POWER + LB;
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

  state_t            r_state;
  logic [CW-1:0]     r_cnt;
  logic              r_write;
  logic [1:0]        r_size;
  logic              r_unsigned;
  logic [XLEN-1:0]   r_addr;
  logic [XLEN-1:0]   r_wdata;
  logic [XLEN-1:0]   r_mem [2**DMEM_POWER];

  logic [LB-1:0]         w_off;
  logic [DMEM_POWER-1:0] w_idx;
  logic                  w_oor;
  logic                  w_mis;
  logic                  w_bad_size;
  logic                  w_err;
  logic                  w_exec;
  logic [NB-1:0]         w_be;
  logic [XLEN-1:0]       w_wsh;
  logic [XLEN-1:0]       w_rsh;
  logic [XLEN-1:0]       w_fmask;
  logic [XLEN-1:0]       w_msb_mask;
  logic                  w_sign;
  logic [XLEN-1:0]       w_ext;

  assign w_off  = r_addr[LB-1:0];
  assign w_idx  = r_addr[AW-1:LB];
  assign w_exec = (r_state == S_BUSY) && (r_cnt == '0);

  generate
    if (AW < XLEN) begin : g_oor
      assign w_oor = |r_addr[XLEN-1:AW];
    end else begin : g_no_oor
      assign w_oor = 1'b0;
    end
  endgenerate

  always_comb begin
    w_mis      = (int'(w_off) & ((1 << r_size) - 1)) != 0;
    w_bad_size = (XLEN == 32) && (r_size == 2'b11);
    w_err      = w_mis || w_bad_size || w_oor;
    w_be       = '0;
    for (int b = 0; b < NB; b++) begin
      w_be[b] = (b >= int'(w_off)) && (b < int'(w_off) + (1 << r_size));
    end
  end

  // Field mask wraps to all ones when the access covers the full word.
  always_comb begin
    w_wsh      = r_wdata << {w_off, 3'b000};
    w_rsh      = r_mem[w_idx] >> {w_off, 3'b000};
    w_fmask    = ({{(XLEN-1){1'b0}}, 1'b1} << (8 << r_size)) - {{(XLEN-1){1'b0}}, 1'b1};
    w_msb_mask = w_fmask & ~(w_fmask >> 1);
    w_sign     = !r_unsigned && |(w_rsh & w_msb_mask);
    w_ext      = (w_rsh & w_fmask) | (w_sign ? ~w_fmask : '0);
  end

  always_ff @(posedge clk) begin
    if (w_exec && r_write && !w_err) begin
      for (int b = 0; b < NB; b++) begin
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wsh[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_write    <= 1'b0;
      r_size     <= 2'b00;
      r_unsigned <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      req_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_write    <= req_write;
            r_size     <= req_size;
            r_unsigned <= req_unsigned;
            r_addr     <= req_addr;
            r_wdata    <= req_wdata;
            r_cnt      <= CW'(LATENCY - 1);
            r_state    <= S_BUSY;
            req_ready  <= 1'b0;
          end
        end
        S_BUSY: begin
          if (r_cnt == '0) begin
            r_state   <= S_RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= w_err;
            rsp_rdata <= (w_err || r_write) ? '0 : w_ext;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_state   <= S_IDLE;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: three instances (32-bit lat 1, 32-bit lat 3, 64-bit lat 2)
// driven by directed scenarios plus random traffic against a byte-array model.
module tb_dmem_ctrl;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_err;

  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_ready;

  logic        a_req_valid, a_req_ready, a_rsp_valid, a_rsp_err;
  logic [31:0] a_rsp_rdata;
  logic        b_req_valid, b_req_ready, b_rsp_valid, b_rsp_err;
  logic [31:0] b_rsp_rdata;

  logic        c_req_valid, c_req_ready, c_req_write, c_req_unsigned;
  logic [1:0]  c_req_size;
  logic [63:0] c_req_addr, c_req_wdata, c_rsp_rdata;
  logic        c_rsp_valid, c_rsp_ready, c_rsp_err;

  logic [7:0]  mdl [1024];

  dmem_ctrl #(.XLEN(32), .DMEM_POWER(8), .LATENCY(1)) u_a (
    .clk(clk), .rst_n(rst_n),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(a_rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err));

  dmem_ctrl #(.XLEN(32), .DMEM_POWER(6), .LATENCY(3)) u_b (
    .clk(clk), .rst_n(rst_n),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(b_rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err));

  dmem_ctrl #(.XLEN(64), .DMEM_POWER(4), .LATENCY(2)) u_c (
    .clk(clk), .rst_n(rst_n),
    .req_valid(c_req_valid), .req_ready(c_req_ready), .req_write(c_req_write),
    .req_size(c_req_size), .req_unsigned(c_req_unsigned), .req_addr(c_req_addr),
    .req_wdata(c_req_wdata), .rsp_valid(c_rsp_valid), .rsp_ready(c_rsp_ready),
    .rsp_rdata(c_rsp_rdata), .rsp_err(c_rsp_err));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // One transaction on a 32-bit instance (sel 0 = u_a, 1 = u_b); entered and left at posedge+1.
  task automatic txn32(input int sel, input logic wr, input logic [1:0] sz, input logic un,
                       input logic [31:0] ad, input logic [31:0] wd,
                       output logic [31:0] rd, output logic er, output int lat);
    req_write = wr; req_size = sz; req_unsigned = un; req_addr = ad; req_wdata = wd;
    rsp_ready = 1'b1;
    if (sel == 0) a_req_valid = 1'b1; else b_req_valid = 1'b1;
    @(posedge clk); #1;
    a_req_valid = 1'b0; b_req_valid = 1'b0;
    lat = 0;
    while (((sel == 0) ? !a_rsp_valid : !b_rsp_valid) && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    if (lat >= 20) begin
      n_checks++; n_err++;
      $display("FAIL timeout32 sel=%0d addr=%h no rsp_valid within 20 cycles", sel, ad);
    end
    rd = (sel == 0) ? a_rsp_rdata : b_rsp_rdata;
    er = (sel == 0) ? a_rsp_err : b_rsp_err;
    @(posedge clk); #1;
  endtask

  task automatic txn64(input logic wr, input logic [1:0] sz, input logic un,
                       input logic [63:0] ad, input logic [63:0] wd,
                       output logic [63:0] rd, output logic er, output int lat);
    c_req_write = wr; c_req_size = sz; c_req_unsigned = un; c_req_addr = ad; c_req_wdata = wd;
    c_rsp_ready = 1'b1; c_req_valid = 1'b1;
    @(posedge clk); #1;
    c_req_valid = 1'b0;
    lat = 0;
    while (!c_rsp_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    if (lat >= 20) begin
      n_checks++; n_err++;
      $display("FAIL timeout64 addr=%h no rsp_valid within 20 cycles", ad);
    end
    rd = c_rsp_rdata; er = c_rsp_err;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #12;
    n_checks++;
    if (a_req_ready !== 1'b1 || a_rsp_valid !== 1'b0 || a_rsp_rdata !== 32'h0 || a_rsp_err !== 1'b0) begin
      n_err++;
      $display("FAIL reset_a got rdy=%b vld=%b rd=%h err=%b exp 1 0 0 0", a_req_ready, a_rsp_valid, a_rsp_rdata, a_rsp_err);
    end
    n_checks++;
    if (b_req_ready !== 1'b1 || b_rsp_valid !== 1'b0 || b_rsp_rdata !== 32'h0 || b_rsp_err !== 1'b0) begin
      n_err++;
      $display("FAIL reset_b got rdy=%b vld=%b rd=%h err=%b exp 1 0 0 0", b_req_ready, b_rsp_valid, b_rsp_rdata, b_rsp_err);
    end
    n_checks++;
    if (c_req_ready !== 1'b1 || c_rsp_valid !== 1'b0 || c_rsp_rdata !== 64'h0 || c_rsp_err !== 1'b0) begin
      n_err++;
      $display("FAIL reset_c got rdy=%b vld=%b rd=%h err=%b exp 1 0 0 0", c_req_ready, c_rsp_valid, c_rsp_rdata, c_rsp_err);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [31:0] rd; logic er; int lat;
    txn32(0, 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, rd, er, lat);
    n_checks++;
    if (rd !== 32'h0 || er !== 1'b0 || lat != 1) begin
      n_err++;
      $display("FAIL sw_basic got rd=%h err=%b lat=%0d exp 0 0 1", rd, er, lat);
    end
    txn32(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd, er, lat);
    n_checks++;
    if (rd !== 32'hDEADBEEF || er !== 1'b0 || lat != 1) begin
      n_err++;
      $display("FAIL lw_basic got rd=%h err=%b lat=%0d exp deadbeef 0 1", rd, er, lat);
    end
  endtask

  task automatic test_subword();
    logic [31:0] rd; logic er; int lat;
    txn32(0, 1'b1, 2'd0, 1'b0, 32'h11, 32'h12345680, rd, er, lat);
    txn32(0, 1'b0, 2'd0, 1'b0, 32'h11, 32'h0, rd, er, lat);
    n_checks++;
    if (rd !== 32'hFFFFFF80 || er !== 1'b0) begin
      n_err++;
      $display("FAIL lb_signed got rd=%h err=%b exp ffffff80 0", rd, er);
    end
    txn32(0, 1'b0, 2'd0, 1'b1, 32'h11, 32'h0, rd, er, lat);
    n_checks++;
    if (rd !== 32'h00000080 || er !== 1'b0) begin
      n_err++;
      $display("FAIL lbu got rd=%h err=%b exp 00000080 0", rd, er);
    end
    txn32(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd, er, lat);
    n_checks++;
    if (rd !== 32'hDEAD80EF || er !== 1'b0) begin
      n_err++;
      $display("FAIL lw_after_sb got rd=%h err=%b exp dead80ef 0", rd, er);
    end
    txn32(0, 1'b0, 2'd1, 1'b0, 32'h12, 32'h0, rd, er, lat);
    n_checks++;
    if (rd !== 32'hFFFFDEAD || er !== 1'b0) begin
      n_err++;
      $display("FAIL lh_hi got rd=%h err=%b exp ffffdead 0", rd, er);
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er; int lat;
    txn32(0, 1'b0, 2'd1, 1'b0, 32'h13, 32'h0, rd, er, lat);
    n_checks++;
    if (rd !== 32'h0 || er !== 1'b1 || lat != 1) begin
      n_err++;
      $display("FAIL lh_misaligned got rd=%h err=%b lat=%0d exp 0 1 1", rd, er, lat);
    end
    txn32(0, 1'b1, 2'd2, 1'b0, 32'h12, 32'h55555555, rd, er, lat);
    n_checks++;
    if (rd !== 32'h0 || er !== 1'b1) begin
      n_err++;
      $display("FAIL sw_misaligned got rd=%h err=%b exp 0 1", rd, er);
    end
    txn32(0, 1'b1, 2'd3, 1'b0, 32'h0, 32'h66666666, rd, er, lat);
    n_checks++;
    if (rd !== 32'h0 || er !== 1'b1) begin
      n_err++;
      $display("FAIL size11_xlen32 got rd=%h err=%b exp 0 1", rd, er);
    end
    txn32(0, 1'b1, 2'd2, 1'b0, 32'h410, 32'h77777777, rd, er, lat);
    n_checks++;
    if (rd !== 32'h0 || er !== 1'b1) begin
      n_err++;
      $display("FAIL out_of_range got rd=%h err=%b exp 0 1", rd, er);
    end
    txn32(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd, er, lat);
    n_checks++;
    if (rd !== 32'hDEAD80EF || er !== 1'b0) begin
      n_err++;
      $display("FAIL word_unchanged got rd=%h err=%b exp dead80ef 0", rd, er);
    end
  endtask

  task automatic test_latency_backpressure();
    logic [31:0] rd; logic er; int lat; int first;
    txn32(1, 1'b1, 2'd2, 1'b0, 32'h4, 32'hCAFEF00D, rd, er, lat);
    req_write = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 32'h4;
    rsp_ready = 1'b0; b_req_valid = 1'b1;
    @(posedge clk); #1;
    b_req_valid = 1'b0;
    first = -1;
    for (int k = 1; k <= 6; k++) begin
      if (b_rsp_valid && first < 0) first = k - 1;
      if (first < 0) begin @(posedge clk); #1; end
    end
    n_checks++;
    if (first != 3) begin
      n_err++;
      $display("FAIL lat3_rise got rsp_valid after %0d cycles exp 3", first);
    end
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (b_rsp_valid !== 1'b1 || b_rsp_rdata !== 32'hCAFEF00D || b_rsp_err !== 1'b0 || b_req_ready !== 1'b0) begin
        n_err++;
        $display("FAIL hold_stable cyc=%0d got vld=%b rd=%h err=%b rdy=%b exp 1 cafef00d 0 0",
                 k, b_rsp_valid, b_rsp_rdata, b_rsp_err, b_req_ready);
      end
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    n_checks++;
    if (b_req_ready !== 1'b0 || b_rsp_valid !== 1'b1) begin
      n_err++;
      $display("FAIL ready_before_take got rdy=%b vld=%b exp 0 1", b_req_ready, b_rsp_valid);
    end
    @(posedge clk); #1;
    n_checks++;
    if (b_req_ready !== 1'b1 || b_rsp_valid !== 1'b0) begin
      n_err++;
      $display("FAIL ready_after_take got rdy=%b vld=%b exp 1 0", b_req_ready, b_rsp_valid);
    end
  endtask

  task automatic test_reset_mid_busy();
    logic [31:0] rd; logic er; int lat;
    txn32(1, 1'b1, 2'd2, 1'b0, 32'h20, 32'h11223344, rd, er, lat);
    req_write = 1'b1; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 32'h20;
    req_wdata = 32'hAAAAAAAA; rsp_ready = 1'b1; b_req_valid = 1'b1;
    @(posedge clk); #1;
    b_req_valid = 1'b0;
    n_checks++;
    if (b_req_ready !== 1'b0) begin
      n_err++;
      $display("FAIL busy_before_reset got rdy=%b exp 0", b_req_ready);
    end
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (b_req_ready !== 1'b1 || b_rsp_valid !== 1'b0 || b_rsp_rdata !== 32'h0 || b_rsp_err !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset got rdy=%b vld=%b rd=%h err=%b exp 1 0 0 0", b_req_ready, b_rsp_valid, b_rsp_rdata, b_rsp_err);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    txn32(1, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, rd, er, lat);
    n_checks++;
    if (rd !== 32'h11223344 || er !== 1'b0 || lat != 3) begin
      n_err++;
      $display("FAIL store_aborted got rd=%h err=%b lat=%0d exp 11223344 0 3", rd, er, lat);
    end
  endtask

  task automatic test_wide();
    logic [63:0] rd; logic er; int lat;
    txn64(1'b1, 2'd3, 1'b0, 64'h8, 64'h0123456789ABCDEF, rd, er, lat);
    n_checks++;
    if (rd !== 64'h0 || er !== 1'b0 || lat != 2) begin
      n_err++;
      $display("FAIL sd got rd=%h err=%b lat=%0d exp 0 0 2", rd, er, lat);
    end
    txn64(1'b0, 2'd2, 1'b0, 64'hC, 64'h0, rd, er, lat);
    n_checks++;
    if (rd !== 64'h0000000001234567 || er !== 1'b0) begin
      n_err++;
      $display("FAIL lw_hi64 got rd=%h err=%b exp 0000000001234567 0", rd, er);
    end
    txn64(1'b0, 2'd2, 1'b0, 64'h8, 64'h0, rd, er, lat);
    n_checks++;
    if (rd !== 64'hFFFFFFFF89ABCDEF || er !== 1'b0) begin
      n_err++;
      $display("FAIL lw_lo64 got rd=%h err=%b exp ffffffff89abcdef 0", rd, er);
    end
    txn64(1'b0, 2'd2, 1'b1, 64'h8, 64'h0, rd, er, lat);
    n_checks++;
    if (rd !== 64'h0000000089ABCDEF || er !== 1'b0) begin
      n_err++;
      $display("FAIL lwu64 got rd=%h err=%b exp 0000000089abcdef 0", rd, er);
    end
    txn64(1'b0, 2'd3, 1'b0, 64'h8, 64'h0, rd, er, lat);
    n_checks++;
    if (rd !== 64'h0123456789ABCDEF || er !== 1'b0) begin
      n_err++;
      $display("FAIL ld64 got rd=%h err=%b exp 0123456789abcdef 0", rd, er);
    end
    txn64(1'b0, 2'd3, 1'b0, 64'h80, 64'h0, rd, er, lat);
    n_checks++;
    if (rd !== 64'h0 || er !== 1'b1 || lat != 2) begin
      n_err++;
      $display("FAIL oor64 got rd=%h err=%b lat=%0d exp 0 1 2", rd, er, lat);
    end
  endtask

  task automatic test_random();
    logic [31:0] rd, wd, ad, exp_rd; logic er, exp_err, wr, un; logic [1:0] sz;
    int lat, nb;
    longint unsigned v;
    for (int i = 0; i < 16; i++) begin
      wd = $urandom;
      txn32(0, 1'b1, 2'd2, 1'b0, 32'(i * 4), wd, rd, er, lat);
      for (int k = 0; k < 4; k++) mdl[i*4 + k] = wd[8*k +: 8];
    end
    for (int n = 0; n < 150; n++) begin
      wr = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      un = 1'($urandom_range(0, 1));
      wd = $urandom;
      if ($urandom_range(0, 7) == 0) ad = 32'h400 + 32'($urandom_range(0, 255));
      else ad = 32'($urandom_range(0, 63));
      nb = 1 << sz;
      exp_err = (int'(ad) % nb) != 0 || sz == 2'd3 || ad >= 32'd1024;
      exp_rd = 32'h0;
      if (!exp_err) begin
        if (wr) begin
          for (int k = 0; k < nb; k++) mdl[int'(ad) + k] = wd[8*k +: 8];
        end else begin
          v = 0;
          for (int k = 0; k < nb; k++) v |= longint'(mdl[int'(ad) + k]) << (8 * k);
          if (!un && ((v >> (8 * nb - 1)) & 1) != 0) v |= ~64'd0 << (8 * nb);
          exp_rd = v[31:0];
        end
      end
      txn32(0, wr, sz, un, ad, wd, rd, er, lat);
      n_checks++;
      if (rd !== exp_rd || er !== exp_err || lat != 1) begin
        n_err++;
        $display("FAIL random n=%0d wr=%b sz=%0d un=%b addr=%h got rd=%h err=%b lat=%0d exp rd=%h err=%b lat=1",
                 n, wr, sz, un, ad, rd, er, lat, exp_rd, exp_err);
      end
    end
  endtask

  initial begin
    n_checks = 0; n_err = 0;
    rst_n = 1'b0;
    a_req_valid = 1'b0; b_req_valid = 1'b0; c_req_valid = 1'b0;
    req_write = 1'b0; req_size = 2'd0; req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b0;
    c_req_write = 1'b0; c_req_size = 2'd0; c_req_unsigned = 1'b0; c_req_addr = '0;
    c_req_wdata = '0; c_rsp_ready = 1'b0;
    test_reset();
    test_basic();
    test_subword();
    test_errors();
    test_latency_backpressure();
    test_reset_mid_busy();
    test_wide();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
